top_mac_pipe: RTL and testbench

- Parametrised, pipelined unsigned×signed multiply-accumulate.
- Successor to the single-cycle 8u×20s multiplier core used in the HLS datapath.
- Adds configurable widths and pipeline depth, a clock enable, valid tagging, group accumulation (first/last), and round-and-shift output.
- Sits between pixel/feature streams and the template-matching scorer in the plate-recognition pipeline.

---
 rtl/top_mac_pipe.sv | 155 +++++++++++++++
 tb/tb_top_mac_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/top_mac_pipe.sv
// top_mac_pipe: pipelined unsigned x signed multiply-accumulate.
// The product runs through NUM_STAGE pipeline registers, then an accumulator
// stage and an output round/shift stage. Latency is NUM_STAGE+2 ce cycles.
// Optional macro TOP_MAC_SAT_EN: saturate the output to OUT_W and flag ovf;
// without it the output wraps and ovf is tied low.
module top_mac_pipe #(
    parameter int A_W       = 8,
    parameter int B_W       = 20,
    parameter int ACC_W     = 40,
    parameter int OUT_W     = 28,
    parameter int NUM_STAGE = 3,
    parameter int SHIFT     = 0
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic                    acc_en,
    input  logic [A_W-1:0]          din0,
    input  logic signed [B_W-1:0]   din1,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    output logic                    ovf
);

    localparam int P_W = A_W + B_W;

    // Output bounds expressed in the widened (ACC_W+1) rounding domain
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = ~MAXV;

    typedef struct packed {
        logic                  first;
        logic                  last;
        logic                  acc_en;
        logic signed [P_W-1:0] prod;
    } stage_t;

    // Both operands widened to P_W so the product is exact without relying
    // on context-width rules: din0 zero-extends, din1 sign-extends.
    logic signed [P_W-1:0] a_ext, b_ext, prod;
    assign a_ext = {{B_W{1'b0}}, din0};
    assign b_ext = {{A_W{din1[B_W-1]}}, din1};
    assign prod  = a_ext * b_ext;

    stage_t               pipe [1:NUM_STAGE];
    logic [NUM_STAGE:1]   vld_pipe;

    // Valid bits of the multiplier pipeline; the only pipeline state that resets
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_pipe <= '0;
        end else if (ce) begin
            vld_pipe[1] <= in_valid;
            for (int i = 2; i <= NUM_STAGE; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Product and group flags travel alongside the valid bits
    always_ff @(posedge ap_clk) begin
        if (ce) begin
            pipe[1] <= '{first: in_first, last: in_last, acc_en: acc_en, prod: prod};
            for (int i = 2; i <= NUM_STAGE; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    stage_t                  tail;
    logic signed [P_W-1:0]   tail_prod;
    logic signed [ACC_W-1:0] p_ext, sum;
    logic signed [ACC_W-1:0] acc, acc_out;
    logic                    emit;

    assign tail      = pipe[NUM_STAGE];
    assign tail_prod = tail.prod;
    assign p_ext     = ACC_W'(tail_prod);
    assign sum       = (tail.first ? '0 : acc) + p_ext;

    // Accumulator stage: pass-through products leave the open group alone;
    // a group emits on its last term and then restarts from zero.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc     <= '0;
            acc_out <= '0;
            emit    <= 1'b0;
        end else if (ce) begin
            emit <= 1'b0;
            if (vld_pipe[NUM_STAGE]) begin
                if (!tail.acc_en) begin
                    acc_out <= p_ext;
                    emit    <= 1'b1;
                end else if (tail.last) begin
                    acc_out <= sum;
                    emit    <= 1'b1;
                    acc     <= '0;
                end else begin
                    acc     <= sum;
                end
            end
        end
    end

    // Round-half-up then arithmetic shift, one bit wider so the bias cannot overflow
    logic signed [ACC_W:0] r_full;
    generate
        if (SHIFT > 0) begin : g_shift
            localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) <<< (SHIFT-1);
            assign r_full = ($signed({acc_out[ACC_W-1], acc_out}) + RND) >>> SHIFT;
        end else begin : g_noshift
            assign r_full = $signed({acc_out[ACC_W-1], acc_out});
        end
    endgenerate

    logic signed [OUT_W-1:0] r_out;
    logic                    r_sat;

`ifdef TOP_MAC_SAT_EN
    // Clamp to the nearest representable bound and flag it
    always_comb begin
        r_out = r_full[OUT_W-1:0];
        r_sat = 1'b0;
        if (r_full > MAXV) begin
            r_out = MAXV[OUT_W-1:0];
            r_sat = 1'b1;
        end else if (r_full < MINV) begin
            r_out = MINV[OUT_W-1:0];
            r_sat = 1'b1;
        end
    end
`else
    // Two's-complement wrap: upper bits are simply dropped
    logic unused_hi;
    assign unused_hi = ^{r_full[ACC_W:OUT_W], MAXV, MINV};
    assign r_out     = r_full[OUT_W-1:0];
    assign r_sat     = 1'b0;
`endif

    // Output register: dout only moves when a result is emitted
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
        end else if (ce) begin
            dout_valid <= emit;
            ovf        <= emit & r_sat;
            if (emit)
                dout <= r_out;
        end
    end

endmodule

// File: tb/tb_top_mac_pipe.sv
// Bench for top_mac_pipe: two instances (SHIFT=0 and SHIFT=4) share stimulus.
// A reference model computes each emitted result arithmetically when the
// sample is accepted and schedules it NUM_STAGE+2 ce edges later.
module tb_top_mac_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ce, iv, fst, lst, aen;
    logic [7:0] a;
    logic signed [19:0] b;
    logic signed [27:0] d0, d1;
    logic v0, v1, o0, o1;

    top_mac_pipe #(.SHIFT(0)) u0 (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(iv), .in_first(fst),
        .in_last(lst), .acc_en(aen), .din0(a), .din1(b),
        .dout(d0), .dout_valid(v0), .ovf(o0));

    top_mac_pipe #(.SHIFT(4)) u1 (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(iv), .in_first(fst),
        .in_last(lst), .acc_en(aen), .din0(a), .din1(b),
        .dout(d1), .dout_valid(v1), .ovf(o1));

    typedef struct {
        longint             due;
        logic signed [27:0] d;
        logic               o;
    } exp_t;

    exp_t q0[$], q1[$];
    longint cyc, macc;
    int total, bad;
    logic signed [27:0] e_d0, e_d1;
    logic e_v0, e_v1, e_o0, e_o1;

    function automatic exp_t reduce(longint v, int sh, longint due);
        exp_t e;
        longint r;
        logic signed [27:0] t;
        r = v;
        if (sh > 0) r = (v + (64'sd1 <<< (sh - 1))) >>> sh;
        e.o = 1'b0;
`ifdef TOP_MAC_SAT_EN
        if (r > 134217727) begin r = 134217727; e.o = 1'b1; end
        else if (r < -134217728) begin r = -134217728; e.o = 1'b1; end
`endif
        t = r[27:0];
        e.d = t;
        e.due = due;
        return e;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input logic r_i, input logic c_i, input logic v_i, input logic f_i,
                        input logic l_i, input logic en_i, input int a_i, input int b_i);
        longint p, v;
        bit emit;
        emit = 0;
        v = 0;
        rst = r_i; ce = c_i; iv = v_i; fst = f_i; lst = l_i; aen = en_i;
        a = 8'(a_i); b = 20'(b_i);
        @(posedge clk);
        if (r_i) begin
            q0.delete(); q1.delete();
            macc = 0;
            e_d0 = '0; e_d1 = '0; e_v0 = 0; e_v1 = 0; e_o0 = 0; e_o1 = 0;
        end else if (c_i) begin
            if (v_i) begin
                p = longint'(a_i) * longint'(b_i);
                if (!en_i) begin
                    v = p; emit = 1;
                end else begin
                    v = (f_i ? 64'sd0 : macc) + p;
                    v = (v <<< 24) >>> 24;     // wrap to 40 bits
                    if (l_i) begin emit = 1; macc = 0; end
                    else macc = v;
                end
                if (emit) begin
                    q0.push_back(reduce(v, 0, cyc + 5));
                    q1.push_back(reduce(v, 4, cyc + 5));
                end
            end
            cyc++;
            e_v0 = 0; e_o0 = 0; e_v1 = 0; e_o1 = 0;
            if (q0.size() > 0 && q0[0].due == cyc) begin
                e_v0 = 1; e_d0 = q0[0].d; e_o0 = q0[0].o; void'(q0.pop_front());
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e_v1 = 1; e_d1 = q1[0].d; e_o1 = q1[0].o; void'(q1.pop_front());
            end
        end
        #1;
        chk("s0_valid", 32'(v0), 32'(e_v0));
        chk("s0_dout",  32'(d0), 32'(e_d0));
        chk("s0_ovf",   32'(o0), 32'(e_o0));
        chk("s4_valid", 32'(v1), 32'(e_v1));
        chk("s4_dout",  32'(d1), 32'(e_d1));
        chk("s4_ovf",   32'(o1), 32'(e_o1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; macc = 0;
        e_d0 = '0; e_d1 = '0; e_v0 = 0; e_v1 = 0; e_o0 = 0; e_o1 = 0;
        rst = 1; ce = 1; iv = 0; fst = 0; lst = 0; aen = 0; a = '0; b = '0;

        // reset state
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // pass-through at the negative limit of din1
        step(0, 1, 1, 0, 0, 0, 255, -524288);
        idle(6);

        // four-term group, only the last term emits
        step(0, 1, 1, 1, 0, 1, 10, 100);
        step(0, 1, 1, 0, 0, 1, 10, 100);
        step(0, 1, 1, 0, 0, 1, 10, 100);
        step(0, 1, 1, 0, 1, 1, 10, 100);
        idle(6);

        // overflowing two-term group
        step(0, 1, 1, 1, 0, 1, 255, 524287);
        step(0, 1, 1, 0, 1, 1, 255, 524287);
        idle(6);

        // rounding boundaries (visible on the SHIFT=4 instance)
        step(0, 1, 1, 0, 0, 0, 1, -8);
        step(0, 1, 1, 0, 0, 0, 1, 24);
        step(0, 1, 1, 0, 0, 0, 1, -24);
        idle(6);

        // stall of three cycles with a sample mid-pipeline
        step(0, 1, 1, 0, 0, 0, 77, -1234);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(6);

        // stall while dout_valid is high must hold it
        step(0, 1, 1, 0, 0, 0, 3, 5);
        idle(4);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // reset mid-group and with a pass-through sample in flight
        step(0, 1, 1, 1, 0, 1, 1, 3);
        step(0, 1, 1, 0, 0, 0, 9, 9);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        idle(6);
        step(0, 1, 1, 1, 0, 1, 1, 5);
        step(0, 1, 1, 0, 1, 1, 1, 7);
        idle(6);

        // last without first starts from the cleared accumulator
        step(0, 1, 1, 0, 1, 1, 1, 9);
        // pass-through in the middle of an open group leaves it intact
        step(0, 1, 1, 1, 0, 1, 2, 50);
        step(0, 1, 1, 0, 0, 0, 4, -6);
        step(0, 1, 0, 0, 0, 1, 200, 200);
        step(0, 1, 1, 0, 1, 1, 3, 30);
        idle(6);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) != 0,
                 int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1048575)) - 524288);
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
